csa_pair_resolver: RTL and testbench



---
 rtl/csa_pair_resolver.sv | 64 ++++++
 tb/tb_csa_pair_resolver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_pair_resolver.sv
// csa_pair_resolver: resolves a carry-save (sum, carry) pair to binary, one CHUNK-bit slice per cycle
module csa_pair_resolver #(
  parameter int W     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] sum_in,
  input  logic [W-1:0] carry_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         busy
);
  localparam int NCHUNK = W / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  if (W % CHUNK != 0) begin : g_chk
    $error("W must be an exact multiple of CHUNK");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] a, b;
  logic [IW-1:0] idx;
  logic c;
  logic last;
  logic [CHUNK:0] s;
  assign last = idx == IW'(NCHUNK - 1);
  assign s = {1'b0, a[idx*CHUNK +: CHUNK]} + {1'b0, b[idx*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, c};
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = (state == IDLE && in_valid) ? BUSY :
               (state == BUSY && last)     ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      idx <= '0;
      c <= 1'b0;
      result <= '0;
      cout <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a <= sum_in;
      b <= carry_in;
      idx <= '0;
      c <= 1'b0;
    end else if (state == BUSY) begin
      result[idx*CHUNK +: CHUNK] <= s[CHUNK-1:0];
      c <= s[CHUNK];
      idx <= idx + 1'b1;
      if (last) cout <= s[CHUNK];
    end
  end
endmodule

// File: tb/tb_csa_pair_resolver.sv
// tb_csa_pair_resolver: table vectors, handshake corner sequences and a randomised scoreboard run
module tb_csa_pair_resolver;
  localparam int W = 32;
  localparam int NCHUNK = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] sum_in = '0;
  logic [W-1:0] carry_in = '0;
  logic in_ready, out_valid, cout, busy;
  logic [W-1:0] result;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_out = 0;
  int n_ov = 0;
  bit lat_pending = 0;
  logic [W-1:0] last_res;
  logic last_cout;
  logic [W:0] exp_q[$];
  int acc_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic c;
  } vec_t;
  vec_t vecs[6];

  csa_pair_resolver #(.W(W), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: inputs sampled mid-cycle predict the accept on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      lat_pending = 0;
    end else begin
      if (exp_q.size() != 0) begin
        chk("in_ready_low_in_flight", in_ready, 0);
        chk("busy_high_in_flight", busy, 1);
      end
      if (out_valid) begin
        n_ov++;
        if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          if (lat_pending) begin
            chk("latency", cyc - acc_q[$], NCHUNK);
            lat_pending = 0;
          end
          chk("result", result, exp_q[0][W-1:0]);
          chk("cout", cout, exp_q[0][W]);
          if (out_ready) begin
            last_res = result;
            last_cout = cout;
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, sum_in} + {1'b0, carry_in});
        acc_q.push_back(cyc + 1);
        n_acc++;
        lat_pending = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string name);
    int n;
    n = n_acc;
    for (int i = 0; i < 50 && n_acc == n; i++) tick();
    if (n_acc == n) chk({name, "_accept_timeout"}, 0, 1);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    sum_in = a;
    carry_in = b;
    in_valid = 1'b1;
    wait_accept("send");
    in_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int i;
    for (i = 0; i < limit && (exp_q.size() != 0 || !in_ready); i++) tick();
    if (i == limit) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int ov0, acc0, sent;
    vecs[0] = '{32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[2] = '{32'h12345678, 32'h11111111, 32'h23456789, 1'b0};
    vecs[3] = '{32'h00FF00FF, 32'hFF00FF01, 32'h00000000, 1'b1};
    vecs[4] = '{32'h00000003, 32'h00000004, 32'h00000007, 1'b0};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1};
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
    tick();

    out_ready = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b);
      drain(50);
      chk($sformatf("vec%0d_result", i), last_res, vecs[i].r);
      chk($sformatf("vec%0d_cout", i), last_cout, vecs[i].c);
    end

    // Output stall: second pair presented but must not be taken until the handshake.
    out_ready = 1'b0;
    send(32'h80000000, 32'h80000000);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    acc0 = n_acc;
    sum_in = 32'h00000001;
    carry_in = 32'h00000002;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_result", result, 32'h0);
      chk("stall_cout", cout, 1);
    end
    chk("stall_no_accept", n_acc, acc0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("stall_in_ready_after", in_ready, 1);
    chk("stall_handoff_result", last_res, 32'h0);
    chk("stall_handoff_cout", last_cout, 1);
    chk("stall_hold_after", result, 32'h0);

    // Back-to-back accepts with in_valid held high.
    sum_in = 32'h12345678;
    carry_in = 32'h11111111;
    in_valid = 1'b1;
    wait_accept("b2b_first");
    sum_in = 32'h00FF00FF;
    carry_in = 32'hFF00FF01;
    wait_accept("b2b_second");
    in_valid = 1'b0;
    chk("b2b_accept_gap", acc_q[$] - acc_q[$-1], NCHUNK + 2);
    drain(50);
    chk("b2b_result", last_res, 32'h0);
    chk("b2b_cout", last_cout, 1);

    // Reset during the second BUSY cycle abandons the operation.
    ov0 = n_ov;
    send(32'hDEADBEEF, 32'h01234567);
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_result", result, 0);
    chk("abort_cout", cout, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_no_valid", n_ov, ov0);
    send(32'h00000003, 32'h00000004);
    drain(50);
    chk("after_abort_result", last_res, 32'h7);

    // Randomised run with output stalls; scoreboard checks every handoff.
    acc0 = n_acc;
    ov0 = n_out;
    sent = 0;
    for (int i = 0; i < 20000 && (sent < 1000 || exp_q.size() != 0); i++) begin
      out_ready = $urandom_range(0, 3) != 0;
      if (!in_valid && sent < 1000 && $urandom_range(0, 1) == 1) begin
        sum_in = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
        carry_in = ($urandom_range(0, 7) == 0) ? 32'h00000001 : $urandom;
        in_valid = 1'b1;
      end
      tick();
      if (n_acc - acc0 > sent) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("rand_accepted", n_acc - acc0, 1000);
    chk("rand_delivered", n_out - ov0, 1000);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
